// File: rtl/pipe_stage_buf_pkg.sv
// Shared definitions for the two-entry skid pipeline stage: state encoding and default sizes.
package pipe_stage_buf_pkg;

    localparam int unsigned DefaultWidth = 32;
    localparam int unsigned DefaultCntW  = 16;

    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StOne   = 2'd1,
        StFull  = 2'd2
    } state_e;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at its all-ones value instead of wrapping.
module sat_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else if (inc && (count_q != '1)) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pipe_stage_buf.sv
// Two-entry skid buffer pipeline stage with registered in_ready and synchronous flush.
// Optional stall/flush statistics counters are built when PIPE_STAGE_STATS_EN is defined.
module pipe_stage_buf
    import pipe_stage_buf_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth,
    parameter int unsigned CNT_W = DefaultCntW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
`ifdef PIPE_STAGE_STATS_EN
    ,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
`endif
);

    if (WIDTH < 1 || CNT_W < 1) begin : gen_param_check
        $error("pipe_stage_buf: WIDTH and CNT_W must be at least 1");
    end

    state_e           state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             in_ready_q;
    logic             in_fire, out_fire;

    assign out_valid = (state_q != StEmpty);
    assign out_data  = main_q;
    assign in_ready  = in_ready_q;
    assign in_fire   = in_valid & in_ready_q & ~flush;
    assign out_fire  = out_valid & out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = StEmpty;
            main_d  = '0;
            skid_d  = '0;
        end else begin
            case (state_q)
                StEmpty: begin
                    if (in_fire) begin
                        main_d  = in_data;
                        state_d = StOne;
                    end
                end
                StOne: begin
                    if (in_fire && out_fire) begin
                        main_d = in_data;
                    end else if (in_fire) begin
                        skid_d  = in_data;
                        state_d = StFull;
                    end else if (out_fire) begin
                        // Main is zeroed on drain so out_data reads 0 while idle.
                        main_d  = '0;
                        state_d = StEmpty;
                    end
                end
                StFull: begin
                    if (out_fire) begin
                        main_d  = skid_q;
                        skid_d  = '0;
                        state_d = StOne;
                    end
                end
                default: begin
                    state_d = StEmpty;
                    main_d  = '0;
                    skid_d  = '0;
                end
            endcase
        end
    end

    // in_ready comes from the next-state so it is a pure register output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StEmpty;
            main_q     <= '0;
            skid_q     <= '0;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
            in_ready_q <= (state_d != StFull);
        end
    end

`ifdef PIPE_STAGE_STATS_EN
    sat_counter #(
        .WIDTH (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (out_valid & ~out_ready),
        .count (stall_cnt)
    );

    sat_counter #(
        .WIDTH (CNT_W)
    ) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (flush & (state_q != StEmpty)),
        .count (flush_cnt)
    );
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Scoreboard bench for pipe_stage_buf: directed scenarios plus a long random run.
module tb_pipe_stage_buf;

    localparam int unsigned W      = 32;
    localparam int unsigned CW     = 4;
    localparam int unsigned SatMax = 15;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
`ifdef PIPE_STAGE_STATS_EN
    logic [CW-1:0] stall_cnt;
    logic [CW-1:0] flush_cnt;
`endif

    int total = 0;
    int bad   = 0;

    logic [W-1:0] exp_q[$];
    int           stall_m = 0;
    int           flush_m = 0;

    pipe_stage_buf #(
        .WIDTH (W),
        .CNT_W (CW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
`ifdef PIPE_STAGE_STATS_EN
        ,
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    // Monitor: model is an ordered queue holding at most two payloads.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            stall_m = 0;
            flush_m = 0;
        end else begin
            automatic bit exp_rdy = (exp_q.size() < 2);
            chk("out_valid", out_valid, exp_q.size() != 0);
            chk("in_ready", in_ready, exp_rdy);
            if (exp_q.size() == 0) chk("idle_data", out_data, 0);
            else chk("out_data", out_data, exp_q[0]);
`ifdef PIPE_STAGE_STATS_EN
            chk("stall_cnt", stall_cnt, stall_m);
            chk("flush_cnt", flush_cnt, flush_m);
`endif
            if (exp_q.size() != 0 && !out_ready && stall_m < SatMax) stall_m++;
            if (flush && exp_q.size() != 0 && flush_m < SatMax) flush_m++;
            if (flush) begin
                exp_q.delete();
            end else begin
                if (out_ready && exp_q.size() != 0) void'(exp_q.pop_front());
                if (in_valid && exp_rdy) exp_q.push_back(in_data);
            end
        end
    end

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        #2;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        step();
        rst = 1'b0;

        // Streaming
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            in_valid = 1'b1; in_data = W'(i);
            step();
            chk("stream_data", out_data, i);
            chk("stream_ready", in_ready, 1);
        end
        in_valid = 1'b0;
        step();
        chk("stream_empty", out_valid, 0);

        // Backpressure
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'hA; step();
        in_data = 32'hB; step();
        in_valid = 1'b0;
        chk("bp_full_ready", in_ready, 0);
        chk("bp_hold", out_data, 32'hA);
        step();
        chk("bp_hold2", out_data, 32'hA);
        out_ready = 1'b1; step();
        chk("bp_second", out_data, 32'hB);
        chk("bp_ready_back", in_ready, 1);
        step();
        chk("bp_drained", out_valid, 0);

        // Flush while full
        do_reset();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'hA; step();
        in_data = 32'hB; step();
        in_data = 32'hC; flush = 1'b1; step();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_valid", out_valid, 0);
        chk("flush_data", out_data, 0);
        chk("flush_ready", in_ready, 1);
`ifdef PIPE_STAGE_STATS_EN
        chk("flush_cnt_one", flush_cnt, 1);
`endif
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("flush_no_c", out_valid, 0);
        end

        // Async reset mid-cycle while holding one entry
        do_reset();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'h5; step();
        in_valid = 1'b0;
        chk("ar_one", out_valid, 1);
        #2 rst = 1'b1;
        #1;
        chk("ar_valid", out_valid, 0);
        chk("ar_data", out_data, 0);
        chk("ar_ready", in_ready, 1);
`ifdef PIPE_STAGE_STATS_EN
        chk("ar_stall", stall_cnt, 0);
        chk("ar_flush", flush_cnt, 0);
`endif
        step();
        rst = 1'b0; in_valid = 1'b1; in_data = 32'h6; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        chk("ar_accept", out_data, 32'h6);

`ifdef PIPE_STAGE_STATS_EN
        // Stall counter saturation
        do_reset();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'h7; step();
        in_valid = 1'b0;
        repeat (20) step();
        chk("sat_15", stall_cnt, SatMax);
        repeat (3) step();
        chk("sat_stay", stall_cnt, SatMax);
`endif

        // Random traffic
        do_reset();
        for (int i = 0; i < 10000; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            in_data   = $urandom;
            flush     = ($urandom_range(0, 63) == 0);
            step();
        end
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        repeat (4) step();
        chk("drain_left", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
